// File: rtl/codec_spi_pkg.sv
// rtl/codec_spi_pkg.sv - shared types, widths and frame helpers for the codec SPI arbiter
package codec_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HI,
    LO,
    HOLD,
    GAP,
    DONE
  } state_e;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 9;
  localparam int RW_BIT   = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Reads carry an all-zero data field; the codec ignores it.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                     input logic              rw,
                                                     input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[RW_BIT]            = rw;
    f[DATA_MSB:DATA_LSB] = (rw == RW_READ) ? '0 : data;
    return f;
  endfunction

endpackage

// File: rtl/codec_spi_shifter.sv
// rtl/codec_spi_shifter.sv - phase divider, 16-bit frame shifter and SPI pin generation
module codec_spi_shifter
  import codec_spi_pkg::*;
#(
  parameter int CLK_DIV = 62,
  parameter int CS_GAP  = 4
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               dout_i,
  output logic               idle_o,
  output logic               fin_o,
  output logic [DATA_W-1:0]  rx_o,
  output logic               cs_n_o,
  output logic               sclk_o,
  output logic               din_o
);

  localparam int               DIV_W    = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV);
  localparam logic [4:0]       BIT_LAST = 5'(FRAME_W - 1);
  localparam logic [4:0]       GAP_LAST = 5'(((CS_GAP > 0) ? CS_GAP : 1) - 1);

  state_e             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [4:0]         cnt_q;
  logic [FRAME_W-1:0] sr_q;
  logic [DATA_W-1:0]  rx_q;
  logic               cs_n_q;
  logic               sclk_q;
  logic               din_q;
  logic               tick;

  // A phase ends when the divider reaches CLK_DIV; no phases run in IDLE or DONE.
  assign tick   = (state_q != IDLE) && (state_q != DONE) && (div_q == DIV_MAX);
  assign idle_o = (state_q == IDLE);
  assign fin_o  = (state_q == GAP) && tick && (cnt_q == GAP_LAST);
  assign rx_o   = rx_q;
  assign cs_n_o = cs_n_q;
  assign sclk_o = sclk_q;
  assign din_o  = din_q;

  // Frame sequencer: divider, bit/gap counting, shifting and registered pin outputs.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      din_q   <= 1'b0;
    end else begin
      div_q <= (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sr_q    <= frame_i;
            din_q   <= frame_i[FRAME_W-1];
            rx_q    <= '0;
            cnt_q   <= '0;
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sclk_q  <= 1'b1;
            state_q <= HI;
          end
        end
        HI: begin
          if (tick) begin
            sclk_q  <= 1'b0;
            state_q <= LO;
          end
        end
        LO: begin
          if (tick) begin
            rx_q  <= {rx_q[DATA_W-2:0], dout_i};
            sr_q  <= {sr_q[FRAME_W-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == BIT_LAST) begin
              din_q   <= 1'b0;
              state_q <= HOLD;
            end else begin
              din_q   <= sr_q[FRAME_W-2];
              sclk_q  <= 1'b1;
              state_q <= HI;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == GAP_LAST) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/codec_spi_arbiter.sv
// rtl/codec_spi_arbiter.sv - round-robin arbiter sharing the codec SPI port between two requesters
module codec_spi_arbiter
  import codec_spi_pkg::*;
#(
  parameter int CLK_DIV = 62,
  parameter int CS_GAP  = 4
) (
  input  logic        iCLK_50,
  input  logic        iRESET_n,
  input  logic [1:0]  iREQ_VALID,
  input  logic [1:0]  iREQ_RW,
  input  logic [13:0] iREQ_ADDR,
  input  logic [15:0] iREQ_WDATA,
  output logic [1:0]  oREQ_ACK,
  output logic [1:0]  oREQ_DONE,
  output logic [7:0]  oRDATA,
  output logic        oBUSY,
  output logic        oCS_n,
  output logic        oSCLK,
  output logic        oDIN,
  input  logic        iDOUT
);

  logic               ptr_q;
  logic               gnt_q;
  logic               rw_q;
  logic [1:0]         ack_q;
  logic [1:0]         done_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               busy_q;

  logic               gnt_d;
  logic               start;
  logic [ADDR_W-1:0]  addr_sel;
  logic [DATA_W-1:0]  wdata_sel;
  logic               rw_sel;
  logic [FRAME_W-1:0] frame;
  logic               idle;
  logic               fin;
  logic [DATA_W-1:0]  rx;

  // Grant the favoured requester if it asks, otherwise the other one; build its frame.
  always_comb begin
    gnt_d     = iREQ_VALID[ptr_q] ? ptr_q : ~ptr_q;
    start     = idle && (|iREQ_VALID);
    addr_sel  = gnt_d ? iREQ_ADDR[13:7] : iREQ_ADDR[6:0];
    wdata_sel = gnt_d ? iREQ_WDATA[15:8] : iREQ_WDATA[7:0];
    rw_sel    = iREQ_RW[gnt_d];
    frame     = build_frame(addr_sel, rw_sel, wdata_sel);
  end

  // Pointer, ACK/DONE routing, busy flag and read-data hold register.
  always_ff @(posedge iCLK_50) begin
    if (!iRESET_n) begin
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      rw_q    <= RW_WRITE;
      ack_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      if (start) begin
        ack_q  <= gnt_d ? 2'b10 : 2'b01;
        gnt_q  <= gnt_d;
        rw_q   <= rw_sel;
        ptr_q  <= ~gnt_d;
        busy_q <= 1'b1;
      end else if (|done_q) begin
        busy_q <= 1'b0;
      end
      if (fin) begin
        done_q <= gnt_q ? 2'b10 : 2'b01;
        if (rw_q == RW_READ) rdata_q <= rx;
      end
    end
  end

  codec_spi_shifter #(
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) u_shifter (
    .clk_i   (iCLK_50),
    .resetn_i(iRESET_n),
    .start_i (start),
    .frame_i (frame),
    .dout_i  (iDOUT),
    .idle_o  (idle),
    .fin_o   (fin),
    .rx_o    (rx),
    .cs_n_o  (oCS_n),
    .sclk_o  (oSCLK),
    .din_o   (oDIN)
  );

  assign oREQ_ACK  = ack_q;
  assign oREQ_DONE = done_q;
  assign oRDATA    = rdata_q;
  assign oBUSY     = busy_q;

endmodule

// File: doc/codec_spi_arbiter.md
Name: codec_spi_arbiter

Overview:
Shares the single audio-codec SPI register port between two requesters and serialises their transactions.
- Requester 0 is the power-up register-table loader; requester 1 is the runtime control path (volume, mute, status polls).
- Round-robin arbitration; each transaction is one 16-bit SPI frame.
- The block generates CS_n and SCLK, shifts DIN and captures DOUT for reads.
- Sits between the requesters and the codec SPI pins.

Parameters:
CLK_DIV, 62, clocks per SCLK half-period minus 1; one phase = CLK_DIV+1 clocks (62 gives ~400 kHz at 50 MHz)
CS_GAP, 4, number of phases CS_n is held high between frames (minimum 1)

Ports:
iCLK_50  in  1  system clock
iRESET_n  in  1  reset, synchronous, active-low
iREQ_VALID  in  2  per-requester request; held until ACK
iREQ_RW  in  2  per-requester: 1=read, 0=write
iREQ_ADDR  in  14  {addr1[6:0], addr0[6:0]} register address
iREQ_WDATA  in  16  {wdata1[7:0], wdata0[7:0]}
oREQ_ACK  out  2  one-clock pulse; request captured
oREQ_DONE  out  2  one-clock pulse; frame and gap complete
oRDATA  out  8  read data; valid with oREQ_DONE of a read, held until next DONE
oBUSY  out  1  high from grant until DONE
oCS_n  out  1  codec chip select
oSCLK  out  1  codec SPI clock
oDIN  out  1  data to codec
iDOUT  in  1  data from codec

Behaviour:
- Reset (iRESET_n low at a clock edge) returns all outputs to reset values on the next clock:
  - oCS_n=1, oSCLK=0, oDIN=0, ACK=0, DONE=0, oRDATA=0, oBUSY=0.
  - State=IDLE; RR pointer favours requester 0.
- Reset mid-frame aborts the frame. CS_n rises next clock. No ACK or DONE is issued for the aborted transaction.
- Frame format, sent MSB first: {addr[6:0], rw, data[7:0]}. For reads the data field is 8'h00.
- Phase tick: the divider counts 0..CLK_DIV while not IDLE and produces a tick at CLK_DIV. The counter is cleared in IDLE.
- IDLE:
  - If any VALID is high, grant per the RR pointer. On a tie, the requester not served last wins.
  - Next clock: ACK[g]=1 for one clock; capture the frame into the shift register; oCS_n=0; oBUSY=1; go to SETUP.
  - The pointer then favours the other requester.
- SETUP: drive oDIN=sr[15], oSCLK=0; on tick go to HI.
- HI: oSCLK=1 (codec samples DIN on rising edge); on tick go to LO.
- LO:
  - oSCLK=0; at the tick, sample iDOUT into rx[0] (shift left) and shift sr left.
  - Increment bit count. If count<16, drive the next DIN and go to HI; else go to HOLD.
- HOLD: oSCLK=0, oCS_n=0 for one phase, then oCS_n=1, go to GAP.
- GAP: oCS_n=1 for CS_GAP phases, then go to DONE.
- DONE:
  - Pulse oREQ_DONE[g] for one clock. If the transaction was a read, oRDATA=rx[7:0] in the same clock.
  - Return to IDLE; oBUSY=0.
- Frame clock count: 1 + 32 phases + 1 HOLD + CS_GAP phases + 1 clock, with phase = CLK_DIV+1.
- VALID dropped before ACK: the request is ignored with no side effects.
- VALID of the granted requester still high after ACK is treated as a new request. It is eligible only after DONE and is subject to RR against the other requester.
- Requests are never accepted while not IDLE. ACK and DONE are never both high in one clock.
- oSCLK never toggles while oCS_n=1.

Decomposition:
- Shared package codec_spi_pkg holds:
  - state enum (IDLE, SETUP, HI, LO, HOLD, GAP, DONE)
  - FRAME_W=16, ADDR_W=7, DATA_W=8
  - RW_READ=1 / RW_WRITE=0
  - frame bit positions (addr 15:9, rw 8, data 7:0)
- Sub-module codec_spi_shifter: phase divider, 16-bit shift/capture, SCLK/CS_n/DIN generation, done strobe.
- The arbiter top holds the RR pointer, grant/ACK/DONE routing and the rdata register.

Test Plan:
- Bench uses CLK_DIV=1, CS_GAP=2 (phase = 2 clocks).
- Write from requester 0: addr=7'h01, wdata=8'h01. Expect one ACK[0] pulse and DIN sequence 16'h0201 MSB first on SCLK rising edges. Expect CS_n low for 68 clocks, then high for 4 clocks, then DONE[0]; oRDATA remains 0.
- Read from requester 1: addr=7'h22. Codec model returns 8'hA5 on DOUT during the last 8 bits. Expect frame 16'h4500 and DONE[1] with oRDATA=8'hA5.
- Both VALID asserted continuously after reset: grants alternate 0,1,0,1. Each DONE precedes the next ACK, and CS_n stays high at least 4 clocks between frames.
- Requester 1 pulses VALID for one clock while requester 0's frame is in flight: no ACK[1] is issued and no second frame is sent.
- iRESET_n low at bit 7 of a frame: CS_n=1 and SCLK=0 on the next clock, no DONE. After release, a new request from requester 1 completes normally with RR favouring requester 0 on ties.
- Back-to-back reads from requester 0 with DOUT values 8'h00 then 8'hFF: oRDATA holds 8'h00 from the first DONE until the second DONE, then becomes 8'hFF.
